hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage core. Sequences the ID-stage control-bubble mux and the pipeline register enables.
- Detects load-use hazards, EX-stage redirects (taken branch / JALR) and data-memory wait.
- Drives idex_bubble_o directly into the control-mux hazard select; gates PC and pipeline registers.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 1, IF/ID flush cycles per redirect (1..3).
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before forced release (1..1023).
- PERF_W, 32, stall counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- id_rs1_i  in  REG_ADDR_W  ID-stage source 1.
- id_rs2_i  in  REG_ADDR_W  ID-stage source 2.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_rd_i  in  REG_ADDR_W  EX-stage destination.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_redirect_i  in  1  EX resolved taken branch or JALR.
- dmem_req_i  in  1  MEM stage accessing data memory.
- dmem_ack_i  in  1  data memory completes this cycle.
- perf_clr_i  in  1  clear stall counter.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  IF/ID load NOP.
- idex_bubble_o  out  1  select zero controls into ID/EX (control mux hazard select).
- pipe_hold_o  out  1  hold ID/EX and EX/MEM registers.
- memwb_bubble_o  out  1  load NOP into MEM/WB.
- mem_timeout_o  out  1  sticky: a memory wait hit MEM_TIMEOUT.
- stall_cycles_o  out  PERF_W  cycles with pc_write_o=0.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Default outputs (no event): pc_write_o=1, ifid_write_o=1; all others 0.
- Outputs are combinational from state plus inputs (same-cycle response). State and counters are registered.
- States: RUN, LOAD_STALL, FLUSH, MEM_WAIT.
- Reset: state=RUN, all counters 0, mem_timeout_o=0, stall_cycles_o=0. Reset mid-stall aborts it; the first cycle after reset uses default outputs unless inputs trigger an event.
- load_use = ex_mem_read_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)). x0 never hazards.
- mem_stall = dmem_req_i & !dmem_ack_i.
- Priority in RUN: mem_stall > ex_redirect_i > load_use.
- RUN, mem_stall:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1.
  - Next state MEM_WAIT; timeout count=1; return state = RUN.
- RUN, redirect:
  - Outputs: pc_write=1 (target taken), ifid_flush=1, idex_bubble=1.
  - If FLUSH_CYCLES>1, go to FLUSH with remaining=FLUSH_CYCLES-1. A simultaneous load_use is ignored (wrong path).
- RUN, load_use:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - If LOAD_USE_STALLS>1, go to LOAD_STALL with remaining=LOAD_USE_STALLS-1.
- LOAD_STALL:
  - Same outputs as RUN load_use. Decrement remaining; return to RUN after it reaches 0.
  - ex_redirect_i is ignored here (the EX stage holds a bubble).
- FLUSH:
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1. Decrement remaining; return to RUN after it reaches 0.
  - A new ex_redirect_i reloads remaining=FLUSH_CYCLES-1.
- mem_stall in LOAD_STALL or FLUSH preempts: enter MEM_WAIT with return state = current state and remaining frozen.
- MEM_WAIT:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1. redirect and load_use are not evaluated.
  - dmem_ack_i=1: the exit cycle uses default outputs, or those of the return state. Next state = return state.
  - Timeout count reaches MEM_TIMEOUT without ack: set mem_timeout_o (sticky until rst_i) and release exactly as if ack had arrived.
- Ack in the same cycle as req: no stall.
- stall_cycles_o increments each cycle pc_write_o=0 and saturates at all-ones. perf_clr_i clears it; when clear and increment coincide, clear wins (result 0).

Decomposition:
- Shared package hazard_pkg holds:
  - hz_state_t enum {RUN, LOAD_STALL, FLUSH, MEM_WAIT}.
  - The REG_ADDR_W default.
  - A NOP control-bundle constant.
- Sub-module hazard_detect: pure combinational load_use and mem_stall logic, so it can be checked formally in isolation.
- FSM, counters and perf counter live in the top.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs2=5 with use_rs2=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then defaults. Repeating with ex_rd=0 -> no stall.
- Same load-use with ex_redirect_i=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall. With FLUSH_CYCLES=2 -> flush held 2 cycles.
- dmem_req=1 and ack low for 4 cycles, then ack -> 4 cycles of pipe_hold=1, memwb_bubble=1, pc_write=0. Defaults on the ack cycle. stall_cycles_o increases by 4.
- MEM_TIMEOUT=8, ack never asserted -> release after 8 stall cycles; mem_timeout_o=1 until rst_i.
- LOAD_USE_STALLS=3: mem_stall arrives in the 2nd LOAD_STALL cycle for 2 cycles -> 2 MEM_WAIT cycles, then 1 remaining bubble cycle. Total pc_write=0 is 5 cycles.
- rst_i asserted during MEM_WAIT -> next cycle state RUN, all outputs at reset values, counter 0. perf_clr_i coinciding with a stall -> counter 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
// FSM state enum, control-bundle struct and its fixed encodings.
package hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;
  localparam int HZ_REM_W      = 3;
  localparam int HZ_TO_W       = 10;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    FLUSH,
    MEM_WAIT
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
    logic memwb_bubble;
  } hz_ctrl_t;

  // No hazard: fetch and advance normally.
  localparam hz_ctrl_t HZ_CTRL_NOP = '{
    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0
  };

  localparam hz_ctrl_t HZ_CTRL_LOAD = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0
  };

  localparam hz_ctrl_t HZ_CTRL_FLUSH = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0
  };

  localparam hz_ctrl_t HZ_CTRL_MEM = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1
  };

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline <-> hazard controller bundle.
// master = pipeline side (drives _i), slave = controller (drives _o).
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = hazard_pkg::HZ_REG_ADDR_W,
  parameter int PERF_W     = 32
);

  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_use_rs1_i;
  logic                  id_use_rs2_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic                  ex_mem_read_i;
  logic                  ex_redirect_i;
  logic                  dmem_req_i;
  logic                  dmem_ack_i;
  logic                  perf_clr_i;

  logic                  pc_write_o;
  logic                  ifid_write_o;
  logic                  ifid_flush_o;
  logic                  idex_bubble_o;
  logic                  pipe_hold_o;
  logic                  memwb_bubble_o;
  logic                  mem_timeout_o;
  logic [PERF_W-1:0]     stall_cycles_o;

  modport master (
    output id_rs1_i, id_rs2_i,
    output id_use_rs1_i, id_use_rs2_i,
    output ex_rd_i, ex_mem_read_i,
    output ex_redirect_i,
    output dmem_req_i, dmem_ack_i,
    output perf_clr_i,
    input  pc_write_o, ifid_write_o,
    input  ifid_flush_o, idex_bubble_o,
    input  pipe_hold_o, memwb_bubble_o,
    input  mem_timeout_o, stall_cycles_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i,
    input  id_use_rs1_i, id_use_rs2_i,
    input  ex_rd_i, ex_mem_read_i,
    input  ex_redirect_i,
    input  dmem_req_i, dmem_ack_i,
    input  perf_clr_i,
    output pc_write_o, ifid_write_o,
    output ifid_flush_o, idex_bubble_o,
    output pipe_hold_o, memwb_bubble_o,
    output mem_timeout_o, stall_cycles_o
  );

endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and data-memory stall detect.
// In: ID sources/uses, EX rd/load, dmem req/ack. Out: load_use, mem_stall.
module hazard_detect #(
  parameter int REG_ADDR_W = hazard_pkg::HZ_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  load_use_o,
  output logic                  mem_stall_o
);

  logic rd_nz;
  logic hit1;
  logic hit2;

  // x0 is hardwired zero, so a load to it never hazards.
  assign rd_nz = |ex_rd_i;
  assign hit1  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign hit2  = id_use_rs2_i && (id_rs2_i == ex_rd_i);

  assign load_use_o  = ex_mem_read_i && rd_nz
                    && (hit1 || hit2);
  assign mem_stall_o = dmem_req_i && !dmem_ack_i;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush/bubble sequencer for the 5-stage core.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of the bundle).
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W      = hazard_pkg::HZ_REG_ADDR_W,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int PERF_W          = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_ctrl_unit_if.slave  bus
);

  import hazard_pkg::*;

  localparam logic [HZ_REM_W-1:0] LU_RELOAD =
    HZ_REM_W'(LOAD_USE_STALLS - 1);
  localparam logic [HZ_REM_W-1:0] FL_RELOAD =
    HZ_REM_W'(FLUSH_CYCLES - 1);
  localparam logic [HZ_TO_W-1:0]  TO_MAX    =
    HZ_TO_W'(MEM_TIMEOUT);
  localparam hz_state_t LU_NEXT =
    (LOAD_USE_STALLS > 1) ? LOAD_STALL : RUN;
  localparam hz_state_t FL_NEXT =
    (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  logic load_use;
  logic mem_stall;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .id_rs1_i      (bus.id_rs1_i),
    .id_rs2_i      (bus.id_rs2_i),
    .id_use_rs1_i  (bus.id_use_rs1_i),
    .id_use_rs2_i  (bus.id_use_rs2_i),
    .ex_rd_i       (bus.ex_rd_i),
    .ex_mem_read_i (bus.ex_mem_read_i),
    .dmem_req_i    (bus.dmem_req_i),
    .dmem_ack_i    (bus.dmem_ack_i),
    .load_use_o    (load_use),
    .mem_stall_o   (mem_stall)
  );

  hz_state_t             state_q, state_d;
  hz_state_t             ret_q, ret_d;
  logic [HZ_REM_W-1:0]   rem_q, rem_d;
  logic [HZ_TO_W-1:0]    to_q, to_d;
  logic                  tmo_q, tmo_d;
  logic [PERF_W-1:0]     stall_q, stall_d;

  hz_ctrl_t  ctrl;
  hz_state_t cur;
  logic      rel;
  logic      ms;
  logic      rem_last;

  // A wait ends on ack (or dropped req) or on timeout; that cycle
  // then behaves exactly like the state the wait interrupted.
  assign rel = (state_q == MEM_WAIT)
            && (!mem_stall || (to_q == TO_MAX));
  assign cur = rel ? ret_q : state_q;
  assign ms  = mem_stall && !rel;
  assign rem_last = (rem_q == HZ_REM_W'(1));

  always_comb begin
    ctrl    = HZ_CTRL_NOP;
    state_d = cur;
    ret_d   = ret_q;
    rem_d   = rem_q;
    to_d    = to_q;
    tmo_d   = tmo_q || (rel && mem_stall);
    stall_d = stall_q;

    if (cur == MEM_WAIT) begin
      ctrl = HZ_CTRL_MEM;
      to_d = to_q + HZ_TO_W'(1);
    end else if (ms) begin
      // Preempt: rem_q stays frozen for the return.
      ctrl    = HZ_CTRL_MEM;
      state_d = MEM_WAIT;
      ret_d   = cur;
      to_d    = HZ_TO_W'(1);
    end else begin
      unique case (cur)
        RUN: begin
          if (bus.ex_redirect_i) begin
            // Redirect wins: a load-use here is wrong-path.
            ctrl    = HZ_CTRL_FLUSH;
            state_d = FL_NEXT;
            rem_d   = FL_RELOAD;
          end else if (load_use) begin
            ctrl    = HZ_CTRL_LOAD;
            state_d = LU_NEXT;
            rem_d   = LU_RELOAD;
          end
        end
        LOAD_STALL: begin
          ctrl    = HZ_CTRL_LOAD;
          rem_d   = rem_q - HZ_REM_W'(1);
          state_d = rem_last ? RUN : LOAD_STALL;
        end
        FLUSH: begin
          ctrl = HZ_CTRL_FLUSH;
          if (bus.ex_redirect_i) begin
            rem_d   = FL_RELOAD;
            state_d = FLUSH;
          end else begin
            rem_d   = rem_q - HZ_REM_W'(1);
            state_d = rem_last ? RUN : FLUSH;
          end
        end
        default: ;
      endcase
    end

    if (bus.perf_clr_i) begin
      stall_d = '0;
    end else if (!ctrl.pc_write && (stall_q != '1)) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      ret_q   <= RUN;
      rem_q   <= '0;
      to_q    <= '0;
      tmo_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      to_q    <= to_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.ifid_write_o   = ctrl.ifid_write;
  assign bus.ifid_flush_o   = ctrl.ifid_flush;
  assign bus.idex_bubble_o  = ctrl.idex_bubble;
  assign bus.pipe_hold_o    = ctrl.pipe_hold;
  assign bus.memwb_bubble_o = ctrl.memwb_bubble;
  assign bus.mem_timeout_o  = tmo_q;
  assign bus.stall_cycles_o = stall_q;

endmodule
